// File: rtl/dl_report_pkg.sv
// Shared types for the deadlock report controller: FSM state encoding and
// the index-width helper used for process-index signals.
package dl_report_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONFIRM = 3'd1,
        ST_ORIGIN  = 3'd2,
        ST_WALK    = 3'd3,
        ST_DONE    = 3'd4
    } dl_state_t;

    // A single process still needs a one-bit index.
    function automatic int dl_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dl_report_prio_enc.sv
// Lowest-set-bit encoder: idx is the lowest index with vec[idx]=1, any flags
// a nonzero vector (idx is 0 when vec is 0).
module dl_report_prio_enc
    import dl_report_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = dl_idx_w(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dl_report_ctrl.sv
// Deadlock report controller: confirms a persistent detect bit, launches the
// report token from one origin and latches the closed dependency cycle.
// Optional walk timeout is enabled with the macro DL_REPORT_TIMEOUT_EN.
module dl_report_ctrl
    import dl_report_pkg::*;
#(
    parameter int PROC_NUM       = 4,
    parameter int CONFIRM_CYCLES = 8,
    parameter int WALK_MAX       = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [PROC_NUM-1:0]           dl_detect_vec,
    input  logic [PROC_NUM-1:0]           token_ret_vec,
    input  logic                          clr,
    output logic                          dl_detect_in,
    output logic [PROC_NUM-1:0]           origin,
    output logic [PROC_NUM-1:0]           token_clear,
    output logic                          dl_valid,
    output logic                          dl_hold,
    output logic                          dl_abort,
    output logic [PROC_NUM-1:0]           dl_path,
    output logic [dl_idx_w(PROC_NUM)-1:0] dl_origin_id
);

    localparam int IDX_W  = dl_idx_w(PROC_NUM);
    localparam int CONF_W = $clog2(CONFIRM_CYCLES + 1);
    localparam logic [PROC_NUM-1:0] ONE = PROC_NUM'(1);

    dl_state_t         state;
    dl_state_t         next_state;
    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  next_cand;
    logic [IDX_W-1:0]  enc_idx;
    logic              enc_any;
    logic [CONF_W-1:0] conf_cnt;
    logic              cand_det;
    logic              conf_reach;
    logic              timeout;

    dl_report_prio_enc #(
        .N     (PROC_NUM),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .vec (dl_detect_vec),
        .idx (enc_idx),
        .any (enc_any)
    );

    // The candidate is only re-chosen from IDLE; later detect bits never move it.
    assign next_cand  = (state == ST_IDLE) ? enc_idx : cand;
    assign cand_det   = dl_detect_vec[cand];
    assign conf_reach = (int'(conf_cnt) + 1) >= CONFIRM_CYCLES;

    always_comb begin
        next_state  = state;
        token_clear = '0;
        case (state)
            ST_IDLE: begin
                if (enc_any)
                    next_state = (CONFIRM_CYCLES <= 1) ? ST_ORIGIN : ST_CONFIRM;
            end
            ST_CONFIRM: begin
                if (!cand_det)
                    next_state = ST_IDLE;
                else if (conf_reach)
                    next_state = ST_ORIGIN;
            end
            ST_ORIGIN: next_state = ST_WALK;
            ST_WALK: begin
                // Closure outranks the timeout when both land in one cycle.
                if (cand_det) begin
                    token_clear = ONE << cand;
                    next_state  = ST_DONE;
                end else if (timeout) begin
                    next_state = ST_IDLE;
                end
            end
            ST_DONE:  next_state = ST_DONE;
            default:  next_state = ST_IDLE;
        endcase
        if (clr)
            next_state = ST_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            cand         <= '0;
            conf_cnt     <= '0;
            origin       <= '0;
            dl_detect_in <= 1'b0;
            dl_valid     <= 1'b0;
            dl_hold      <= 1'b0;
            dl_path      <= '0;
            dl_origin_id <= '0;
        end else begin
            state        <= next_state;
            cand         <= next_cand;
            origin       <= (next_state == ST_ORIGIN) ? (ONE << next_cand) : '0;
            dl_detect_in <= (next_state == ST_ORIGIN) || (next_state == ST_WALK) ||
                            (next_state == ST_DONE);
            dl_hold      <= (next_state == ST_DONE);
            dl_valid     <= (state == ST_WALK) && (next_state == ST_DONE);

            if (next_state == ST_IDLE)
                conf_cnt <= '0;
            else if (state == ST_IDLE)
                conf_cnt <= CONF_W'(1);
            else if (state == ST_CONFIRM && int'(conf_cnt) < CONFIRM_CYCLES)
                conf_cnt <= conf_cnt + 1'b1;

            // The closing-cycle token sample is included before DONE freezes the path.
            if (next_state == ST_IDLE) begin
                dl_path      <= '0;
                dl_origin_id <= '0;
            end else if (next_state == ST_ORIGIN) begin
                dl_path      <= ONE << next_cand;
                dl_origin_id <= next_cand;
            end else if (state == ST_WALK) begin
                dl_path      <= dl_path | token_ret_vec;
            end
        end
    end

`ifdef DL_REPORT_TIMEOUT_EN
    localparam int WALK_W = $clog2(WALK_MAX + 1);

    logic [WALK_W-1:0] walk_cnt;
    logic              abort_q;

    assign timeout  = (state == ST_WALK) && !cand_det && (int'(walk_cnt) >= WALK_MAX - 1);
    assign dl_abort = abort_q;

    always_ff @(posedge clock) begin
        if (reset || state != ST_WALK)
            walk_cnt <= '0;
        else if (int'(walk_cnt) < WALK_MAX)
            walk_cnt <= walk_cnt + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset)
            abort_q <= 1'b0;
        else
            abort_q <= timeout && !clr;
    end
`else
    // Without the timeout the walk waits forever; WALK_MAX has no effect.
    assign timeout  = (WALK_MAX < 0);
    assign dl_abort = 1'b0;
`endif

endmodule
